// File: rtl/multdiv_ctrl_pkg.sv
// multdiv_ctrl_pkg: shared constants, state encoding and decode helpers
// for the multdiv sequencer and its cycle counter.
package multdiv_ctrl_pkg;

    // Opcode field ir[31:27] of R-type instructions.
    localparam logic [4:0]  OPC_RTYPE   = 5'b00000;

    // ALU op field ir[6:2] values served by the multdiv unit.
    localparam logic [4:0]  OP_MUL      = 5'b00110;
    localparam logic [4:0]  OP_DIV      = 5'b00111;

    // rstatus values written on a multdiv exception.
    localparam logic [31:0] RSTATUS_MUL = 32'd4;
    localparam logic [31:0] RSTATUS_DIV = 32'd5;

    // Register index that receives rstatus.
    localparam logic [4:0]  RSTATUS_REG = 5'd30;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        KIND_MUL = 1'b0,
        KIND_DIV = 1'b1
    } kind_t;

    function automatic logic is_md_op(
        input logic [4:0] opc,
        input logic [4:0] alu_op
    );
        return (opc == OPC_RTYPE) &&
               ((alu_op == OP_MUL) || (alu_op == OP_DIV));
    endfunction

    function automatic kind_t kind_of(input logic [4:0] alu_op);
        return (alu_op == OP_DIV) ? KIND_DIV : KIND_MUL;
    endfunction

    function automatic logic [31:0] rstatus_of(input kind_t kind);
        return (kind == KIND_DIV) ? RSTATUS_DIV : RSTATUS_MUL;
    endfunction

endpackage

// File: rtl/multdiv_ctrl_counter.sv
// md_cycle_counter: up-counter with synchronous clear and enable that
// flags the last permitted wait cycle.
//   clock, reset : rising-edge clock, synchronous active-low reset
//   clear        : synchronous clear (wins over enable)
//   enable       : count up by one
//   tc           : count equals MAX_COUNT-1
module md_cycle_counter #(
    parameter int MAX_COUNT = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int W = (MAX_COUNT > 1) ? $clog2(MAX_COUNT + 1) : 1;

    logic [W-1:0] count;

    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + W'(1);
        end
    end

    assign tc = (count == W'(MAX_COUNT - 1));

endmodule

// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: shares the single multi-cycle multdiv unit with the
// pipeline. A mul/div in DX freezes PC/FD/DX, is issued with held
// operands, and its result (or rstatus exception) is offered for the
// DX->XM path until the pipeline accepts it.
//   clock, reset          : rising-edge clock, sync active-low reset
//   dx_ir, dx_a, dx_b     : instruction and bypassed operands in DX
//   md_result/exception/rdy : multdiv unit response
//   wb_ack                : pipeline advances DX->XM this cycle
//   ctrl_MULT, ctrl_DIV   : one-cycle start pulses to multdiv
//   md_a, md_b            : operands held for multdiv
//   stall                 : freeze PC, FD, DX
//   wb_valid/reg/data/ovf : result offered to XM
//   busy                  : sequencer not idle
module multdiv_ctrl
    import multdiv_ctrl_pkg::*;
#(
    parameter int MAX_CYCLES = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] dx_ir,
    input  logic [31:0] dx_a,
    input  logic [31:0] dx_b,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_rdy,
    input  logic        wb_ack,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    output logic        stall,
    output logic        wb_valid,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data,
    output logic        wb_ovf,
    output logic        busy
);

    state_t     state;
    kind_t      kind;
    logic [4:0] rd;

    logic [4:0] ir_opc;
    logic [4:0] ir_rd;
    logic [4:0] ir_alu;
    logic       is_md;
    logic       timeout;
    logic       finish;
    logic       exc_next;

    // Register-source and shamt fields play no part in sequencing.
    logic       unused_ir;

    assign ir_opc    = dx_ir[31:27];
    assign ir_rd     = dx_ir[26:22];
    assign ir_alu    = dx_ir[6:2];
    assign unused_ir = ^{dx_ir[21:7], dx_ir[1:0]};

    assign is_md = is_md_op(ir_opc, ir_alu);

    md_cycle_counter #(
        .MAX_COUNT (MAX_CYCLES)
    ) u_counter (
        .clock  (clock),
        .reset  (reset),
        .clear  (state == S_START),
        .enable (state == S_WAIT),
        .tc     (timeout)
    );

    // A ready response beats the timeout in the same cycle; a timeout
    // alone is always reported as an exception.
    assign finish   = md_rdy | timeout;
    assign exc_next = md_rdy ? md_exception : 1'b1;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= S_IDLE;
            kind      <= KIND_MUL;
            rd        <= '0;
            md_a      <= '0;
            md_b      <= '0;
            ctrl_MULT <= 1'b0;
            ctrl_DIV  <= 1'b0;
            wb_valid  <= 1'b0;
            wb_reg    <= '0;
            wb_data   <= '0;
            wb_ovf    <= 1'b0;
        end else begin
            ctrl_MULT <= 1'b0;
            ctrl_DIV  <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (is_md) begin
                        md_a      <= dx_a;
                        md_b      <= dx_b;
                        rd        <= ir_rd;
                        kind      <= kind_of(ir_alu);
                        ctrl_MULT <= (kind_of(ir_alu) == KIND_MUL);
                        ctrl_DIV  <= (kind_of(ir_alu) == KIND_DIV);
                        state     <= S_START;
                    end
                end
                S_START: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (finish) begin
                        wb_valid <= 1'b1;
                        wb_ovf   <= exc_next;
                        wb_reg   <= exc_next ? RSTATUS_REG : rd;
                        wb_data  <= exc_next ? rstatus_of(kind)
                                             : md_result;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    // DX advances on this same edge, so the op that
                    // just retired is gone before IDLE decodes again.
                    if (wb_ack) begin
                        wb_valid <= 1'b0;
                        wb_ovf   <= 1'b0;
                        wb_reg   <= '0;
                        wb_data  <= '0;
                        state    <= S_IDLE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        stall = 1'b0;
        unique case (state)
            S_IDLE:  stall = is_md;
            S_START: stall = 1'b1;
            S_WAIT:  stall = 1'b1;
            S_DONE:  stall = ~wb_ack;
        endcase
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_multdiv_ctrl.sv
// tb_multdiv_ctrl: randomized and directed scoreboard bench for
// multdiv_ctrl with a behavioural multdiv responder.
module tb_multdiv_ctrl;

    localparam int MAXC = 64;

    logic        clock;
    logic        reset;
    logic [31:0] dx_ir;
    logic [31:0] dx_a;
    logic [31:0] dx_b;
    logic [31:0] md_result;
    logic        md_exception;
    logic        md_rdy;
    logic        wb_ack;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] md_a;
    logic [31:0] md_b;
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        wb_ovf;
    logic        busy;

    multdiv_ctrl #(.MAX_CYCLES(MAXC)) dut (
        .clock        (clock),
        .reset        (reset),
        .dx_ir        (dx_ir),
        .dx_a         (dx_a),
        .dx_b         (dx_b),
        .md_result    (md_result),
        .md_exception (md_exception),
        .md_rdy       (md_rdy),
        .wb_ack       (wb_ack),
        .ctrl_MULT    (ctrl_MULT),
        .ctrl_DIV     (ctrl_DIV),
        .md_a         (md_a),
        .md_b         (md_b),
        .stall        (stall),
        .wb_valid     (wb_valid),
        .wb_reg       (wb_reg),
        .wb_data      (wb_data),
        .wb_ovf       (wb_ovf),
        .busy         (busy)
    );

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        ovf;
    } wb_t;

    wb_t         sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          pulses = 0;
    int          issued = 0;
    int          md_lat = 0;
    int          rsp_cnt = 0;
    logic [31:0] rsp_res;
    logic        rsp_exc;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic void check(input string name,
                                  input logic [31:0] got,
                                  input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endfunction

    // Behavioural multdiv: signed low-word product / signed quotient,
    // exception on product overflow, divide by zero or INT_MIN/-1.
    function automatic void md_compute(input bit is_div,
                                       input logic [31:0] a,
                                       input logic [31:0] b,
                                       output logic [31:0] res,
                                       output logic exc);
        longint p;
        res = '0;
        exc = 1'b0;
        if (is_div) begin
            if (b == 0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) begin
                exc = 1'b1;
            end else begin
                res = $signed(a) / $signed(b);
            end
        end else begin
            p   = longint'($signed(a)) * longint'($signed(b));
            res = p[31:0];
            exc = (p != longint'($signed(p[31:0])));
        end
    endfunction

    // Expected write-back for an op; lat==0 means multdiv never answers.
    function automatic wb_t model(input bit is_div, input logic [4:0] rd,
                                  input logic [31:0] a,
                                  input logic [31:0] b, input int lat);
        wb_t w;
        logic [31:0] r;
        logic e;
        md_compute(is_div, a, b, r, e);
        if (lat == 0) e = 1'b1;
        w.ovf  = e;
        w.rd   = e ? 5'd30 : rd;
        w.data = e ? (is_div ? 32'd5 : 32'd4) : r;
        return w;
    endfunction

    function automatic logic [31:0] enc(input bit is_div,
                                        input logic [4:0] rd);
        logic [14:0] mid;
        mid = 15'($urandom);
        return {5'b00000, rd, mid, (is_div ? 5'b00111 : 5'b00110), 2'b00};
    endfunction

    // Multdiv responder: acts on start pulses using the held operands.
    initial begin
        md_rdy = 1'b0;
        md_exception = 1'b0;
        md_result = '0;
        forever begin
            @(posedge clock);
            #1;
            md_rdy = 1'b0;
            md_exception = 1'b0;
            md_result = '0;
            if (rsp_cnt > 0) begin
                rsp_cnt--;
                if (rsp_cnt == 0) begin
                    md_rdy = 1'b1;
                    md_exception = rsp_exc;
                    md_result = rsp_res;
                end
            end
            if (ctrl_MULT || ctrl_DIV) begin
                md_compute(ctrl_DIV, md_a, md_b, rsp_res, rsp_exc);
                rsp_cnt = md_lat;
            end
        end
    end

    // Monitor: start-pulse accounting and scoreboard pop on accept.
    always @(negedge clock) begin
        wb_t e;
        if (ctrl_MULT || ctrl_DIV) begin
            check("ctrl_exclusive", 32'(ctrl_MULT & ctrl_DIV), 32'd0);
            pulses++;
        end
        if (reset && wb_valid && wb_ack) begin
            if (sb_q.size() == 0) begin
                check("wb_unexpected", 32'(wb_valid), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("wb_reg", 32'(wb_reg), 32'(e.rd));
                check("wb_data", wb_data, e.data);
                check("wb_ovf", 32'(wb_ovf), 32'(e.ovf));
            end
        end
    end

    task automatic run_op(input bit is_div, input logic [4:0] rd,
                          input logic [31:0] a, input logic [31:0] b,
                          input int lat, input int ack_hold,
                          input bit chain);
        wb_t w;
        int  cyc;
        int  eff;
        bit  bad;
        w = model(is_div, rd, a, b, lat);
        sb_q.push_back(w);
        issued++;
        md_lat = lat;
        eff = (lat == 0) ? MAXC : lat;
        dx_ir = enc(is_div, rd);
        dx_a = a;
        dx_b = b;
        wb_ack = (ack_hold == 0);
        @(negedge clock);
        check("idle_stall", 32'(stall), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_wb_valid", 32'(wb_valid), 32'd0);
        @(posedge clock);
        #1;
        @(negedge clock);
        check("start_mult", 32'(ctrl_MULT), 32'(!is_div));
        check("start_div", 32'(ctrl_DIV), 32'(is_div));
        check("start_md_a", md_a, a);
        check("start_md_b", md_b, b);
        cyc = 1;
        bad = 0;
        if (!stall) bad = 1;
        while (cyc < MAXC + 10) begin
            @(posedge clock);
            #1;
            cyc++;
            @(negedge clock);
            if (wb_valid) break;
            if (!stall || !busy) bad = 1;
        end
        check("wait_stall", 32'(bad), 32'd0);
        check("done_seen", 32'(wb_valid), 32'd1);
        check("done_latency", 32'(cyc), 32'(eff + 2));
        for (int i = 0; i < ack_hold; i++) begin
            if (i > 0) begin
                @(posedge clock);
                #1;
                @(negedge clock);
            end
            check("hold_stall", 32'(stall), 32'd1);
            check("hold_valid", 32'(wb_valid), 32'd1);
            check("hold_data", wb_data, w.data);
            check("hold_reg", 32'(wb_reg), 32'(w.rd));
        end
        if (ack_hold > 0) begin
            @(posedge clock);
            #1;
            wb_ack = 1'b1;
            @(negedge clock);
        end
        check("ack_stall", 32'(stall), 32'd0);
        @(posedge clock);
        #1;
        if (!chain) begin
            dx_ir = 32'd0;
            @(negedge clock);
            check("post_valid", 32'(wb_valid), 32'd0);
            check("post_busy", 32'(busy), 32'd0);
            check("post_stall", 32'(stall), 32'd0);
            check("pulse_count", 32'(pulses), 32'(issued));
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, 32'({ctrl_MULT, ctrl_DIV}), 32'd0);
        check({tag, "_md_a"}, md_a, 32'd0);
        check({tag, "_md_b"}, md_b, 32'd0);
        check({tag, "_stall_busy"}, 32'({stall, busy}), 32'd0);
        check({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
        check({tag, "_wb_reg"}, 32'(wb_reg), 32'd0);
        check({tag, "_wb_data"}, wb_data, 32'd0);
        check({tag, "_wb_ovf"}, 32'(wb_ovf), 32'd0);
    endtask

    initial begin
        bit stray;
        reset = 1'b0;
        dx_ir = '0;
        dx_a = '0;
        dx_b = '0;
        wb_ack = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        @(negedge clock);
        check_all_zero("reset");
        @(posedge clock);
        #1;
        reset = 1'b1;

        run_op(1'b0, 5'd3, 32'd7, 32'd6, 32, 0, 1'b0);
        run_op(1'b1, 5'd5, 32'd100, 32'd0, 4, 0, 1'b0);
        run_op(1'b0, 5'd9, 32'h7FFF_FFFF, 32'd2, 3, 0, 1'b0);
        run_op(1'b1, 5'd12, 32'd1000, 32'd7, 5, 3, 1'b0);
        run_op(1'b0, 5'd0, 32'hFFFF_FFFD, 32'd5, 1, 0, 1'b0);
        run_op(1'b1, 5'd7, 32'hFFFF_FF9C, 32'd9, MAXC, 1, 1'b0);
        run_op(1'b0, 5'd4, 32'd11, 32'd13, 0, 0, 1'b0);
        run_op(1'b1, 5'd6, 32'd11, 32'd13, 0, 2, 1'b0);

        // Back-to-back: second op sits in DX right after the accept edge.
        run_op(1'b0, 5'd1, 32'd3, 32'd5, 2, 0, 1'b1);
        run_op(1'b1, 5'd2, 32'd50, 32'd5, 2, 0, 1'b0);

        // Abort mid-WAIT; the late response must be ignored in IDLE.
        issued++;
        md_lat = 20;
        dx_ir = enc(1'b0, 5'd8);
        dx_a = 32'd21;
        dx_b = 32'd2;
        repeat (6) @(posedge clock);
        #1;
        reset = 1'b0;
        dx_ir = 32'd0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        check_all_zero("abort");
        stray = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clock);
            #1;
            @(negedge clock);
            if (wb_valid || busy || stall) stray = 1;
        end
        check("abort_ignored", 32'(stray), 32'd0);
        check("abort_pulses", 32'(pulses), 32'(issued));
        @(posedge clock);
        #1;

        for (int n = 0; n < 12; n++) begin
            bit          kd;
            logic [31:0] a;
            logic [31:0] b;
            kd = 1'($urandom);
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 1) == 1) begin
                a = 32'($urandom_range(0, 5000));
                b = 32'($urandom_range(0, 60));
            end
            run_op(kd, 5'($urandom), a, b, $urandom_range(1, 40),
                   $urandom_range(0, 3), 1'($urandom));
        end
        dx_ir = 32'd0;
        repeat (3) @(posedge clock);
        #1;
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/multdiv_ctrl.md
Name: multdiv_ctrl

Overview:
Sequencer that shares the single multi-cycle multdiv unit with the 5-stage pipeline.
- Detects mul/div in DX and freezes PC/FD/DX.
- Issues one-cycle ctrl_MULT/ctrl_DIV with held operands, then waits for resultRDY or a timeout.
- Presents result or rstatus exception for injection into the DX→XM path, and releases the stall when the pipeline accepts it.

Parameters:
MAX_CYCLES, 64, WAIT-state cycle count after which the op is forced to complete as an exception
OP_MUL, 5'b00110, R-type ALU op field (ir[6:2]) for mul
OP_DIV, 5'b00111, R-type ALU op field for div
RSTATUS_MUL, 32'd4, rstatus value on mul exception
RSTATUS_DIV, 32'd5, rstatus value on div exception

Ports:
clock  in  1  master clock, rising-edge
reset  in  1  synchronous, active-low reset
dx_ir  in  32  instruction currently in DX
dx_a  in  32  operand A after bypass muxing
dx_b  in  32  operand B after bypass muxing
md_result  in  32  multdiv data_result
md_exception  in  1  multdiv data_exception
md_rdy  in  1  multdiv data_resultRDY
wb_ack  in  1  pipeline can advance DX→XM this cycle
ctrl_MULT  out  1  start pulse to multdiv
ctrl_DIV  out  1  start pulse to multdiv
md_a  out  32  held operand A to multdiv
md_b  out  32  held operand B to multdiv
stall  out  1  freeze PC, FD, DX
wb_valid  out  1  wb_data/wb_reg/wb_ovf valid
wb_reg  out  5  destination register: rd, or 30 on exception
wb_data  out  32  result, or rstatus value
wb_ovf  out  1  exception flag for XM ovf bit
busy  out  1  state != IDLE

Behaviour:
- Decode: is_md = (dx_ir[31:27]==0) & (dx_ir[6:2]==OP_MUL | dx_ir[6:2]==OP_DIV). Kind is latched at issue.
- States: IDLE, START, WAIT, DONE. State register is 2 bits.
- Reset (reset==0 at an edge):
  - State goes to IDLE; counter, md_a, md_b, wb_* registers and kind all clear to 0.
  - Every output is 0 the cycle after the reset edge.
  - Reset mid-operation abandons the op. A later md_rdy is ignored unless the block is in WAIT.
- IDLE:
  - stall = is_md, combinational, same cycle.
  - On an edge with is_md=1: capture md_a←dx_a, md_b←dx_b, rd←dx_ir[26:22], kind; go to START.
- START:
  - Exactly one cycle. ctrl_MULT = (kind==mul), ctrl_DIV = (kind==div). Both are registered and never high simultaneously.
  - Clear counter; go to WAIT. stall=1.
- WAIT:
  - stall=1; counter increments each cycle.
  - md_rdy=1: latch md_result and md_exception; go to DONE.
  - Otherwise, counter==MAX_CYCLES-1: latch exception=1; go to DONE.
  - md_rdy has priority over timeout in the same cycle.
- DONE:
  - wb_valid=1.
  - No exception: wb_reg=rd, wb_data=result, wb_ovf=0.
  - Exception: wb_reg=30, wb_data=RSTATUS_MUL or RSTATUS_DIV by kind, wb_ovf=1.
  - stall = ~wb_ack. On an edge with wb_ack=1, go to IDLE. DX advances on the same edge, so the op never re-issues.
  - wb_ack low holds DONE and all wb_* values stable indefinitely.
- md_a and md_b stay constant from capture until the next issue.
- rd==0: passes through unchanged; write suppression belongs to the regfile.
- Latency, issue to wb_valid: 2 cycles + multdiv latency. Stall cycles = that + 1 + wb_ack wait.
- Back-to-back mul/div: the next one in DX is detected in IDLE the cycle after the DONE→IDLE edge. No bubble is inserted by this block.

Decomposition:
- Shared package holds OP_MUL, OP_DIV, RSTATUS_MUL, RSTATUS_DIV, the R-type opcode constant, the state encoding, and the rstatus register index 30.
- One natural sub-module: md_cycle_counter, a parameterised up-counter with sync clear, enable, and terminal-count flag, width $clog2(MAX_CYCLES+1).

Test Plan:
- mul 7×6, rd=r3, md_rdy 32 cycles after ctrl_MULT, wb_ack=1 → one-cycle ctrl_MULT; stall high throughout; wb_valid with wb_reg=3, wb_data=42, wb_ovf=0; stall drops with wb_ack.
- div 100÷0, rd=r5, md_rdy+md_exception → wb_reg=30, wb_data=5, wb_ovf=1.
- mul 0x7FFFFFFF×2 with md_exception → wb_reg=30, wb_data=4, wb_ovf=1.
- Complete a div, hold wb_ack=0 for 3 cycles → DONE held, wb_* stable, stall=1; released on the wb_ack edge with no second ctrl_DIV.
- reset=0 for one edge mid-WAIT, then stray md_rdy → all outputs 0, state IDLE, md_rdy ignored, no wb_valid.
- md_rdy never asserted, MAX_CYCLES=8 → DONE after 8 WAIT cycles with wb_ovf=1 and rstatus by kind.
